oa_tx: RTL and testbench
========================

# oa_tx

Frame transmitter: the PC-bound counterpart of the UART input adapter. On a single-cycle `start` pulse it reads `NUM_BYTES` bytes from the shared register bank, one byte per index from 0 upward, and serialises each byte as 8N1 UART on `tx`. When the frame has been sent it raises `done` for one cycle. It sits between the register bank (read port) and the board's UART TX pin, and contains its own baud counter and shift register.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit; legal range 2..65535.
- `NUM_BYTES`, default 55: bytes per frame, indices 0..NUM_BYTES-1; legal range 1..64.
- `clk` input, 1 bit: the single clock; all state is on the rising edge.
- `reset` input, 1 bit: reset is asynchronous and active-low (0 = reset).
- `start` input, 1 bit: frame request; sampled only in IDLE; a 1-cycle pulse.
- `rd_idx` output, 6 bits: register-bank read index.
- `rd_data` input, 8 bits: bank data for `rd_idx`; combinational, valid in the same cycle.
- `tx` output, 1 bit: UART serial line; idles high.
- `busy` output, 1 bit: high from start acceptance until `done`.
- `done` output, 1 bit: 1-cycle pulse after the final stop bit.

## Operation
- Reset values: `tx`=1, `busy`=0, `done`=0, `rd_idx`=0; state is IDLE; the bit and baud counters are 0.
- States and transitions:
  - **IDLE**: `tx`=1. If `start`=1, set `busy`=1, set `rd_idx`=0, go to FETCH. `start` is ignored in every other state.
  - **FETCH** (1 cycle): at the end of the cycle, latch `rd_data` into the shift register, then go to START.
  - **START**: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - **DATA**: drive shift[0] for CLKS_PER_BIT cycles per bit, LSB first, 8 bits, then go to STOP.
  - **STOP**: `tx`=1 for CLKS_PER_BIT cycles.
    - If `rd_idx` < NUM_BYTES-1: increment `rd_idx`, go to FETCH.
    - Otherwise go to CSUM_LOAD when the checksum is enabled, or to DONE when it is not.
  - **CSUM_LOAD** (1 cycle, present only when the checksum is enabled): load the checksum into the shift register, then go to START. A flag marks this byte as the last one, so the STOP that follows goes to DONE.
  - **DONE** (1 cycle): `done`=1, `busy`=0, `rd_idx`=0, go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and clears on every bit boundary.
  - Width is 16 bits.
  - Wrap is exact; there is no fractional-rate correction.
- `rd_idx` changes only on entry to FETCH or DONE, and is stable for the whole byte.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronously). The partial byte is abandoned and there is no resume.

## Timing
- `start` high in cycle T → `busy`=1 and FETCH in cycle T+1 → `tx` falls in cycle T+2.
- Every byte costs 1 FETCH/LOAD cycle + 10·CLKS_PER_BIT line cycles.
- `done` is high in cycle T+1 + B·(10·CLKS_PER_BIT+1), where B = NUM_BYTES, or NUM_BYTES+1 with the checksum enabled.
- Gap between one stop bit and the next start bit is exactly 1 clock. This 1-cycle gap extends the stop bit and is legal UART.
- A `start` in the same cycle as `done` is ignored. A new frame may start from the cycle after `done`.

## Configuration
- Macro `OA_TX_CHECKSUM_EN`.
- **Defined:**
  - An 8-bit running XOR of all data bytes is accumulated at each FETCH latch; the accumulator clears in IDLE.
  - The checksum is sent as byte NUM_BYTES+1, through the CSUM_LOAD state.
  - `rd_idx` never exceeds NUM_BYTES-1.
- **Undefined:**
  - CSUM_LOAD and the accumulator do not exist.
  - The frame is exactly NUM_BYTES bytes.

## Test plan
- Reset with `reset`=0 → `tx`=1, `busy`=0, `done`=0, `rd_idx`=0. Then release reset with no `start` for 1000 cycles → `tx` stays 1.
- CLKS_PER_BIT=4, NUM_BYTES=3, bank {0xA5, 0x3C, 0xFF}, pulse `start` → bench UART model decodes A5, 3C, FF.
  - Without the macro: `done` at start+1+3·41 = start+124.
  - With the macro: a fourth byte 0x66 follows and `done` is at start+165.
- Pulse `start` repeatedly while `busy`=1 → exactly one frame is sent and `rd_idx` sequence is 0,1,2. Then pulse `start` 1 cycle after `done` → a second, identical frame is sent.
- Drop `reset` low during the DATA bit 3 of byte 1 → `tx`=1 and `busy`=0 in the same cycle. A subsequent `start` sends a full frame beginning at index 0.
- NUM_BYTES=1, CLKS_PER_BIT=2, bank[0]=0x00 → `tx` is low for 18 cycles (start bit plus 8 zero bits), then high; `done` at start+22 without the macro.
- Bank changed only while the block is in STOP → each transmitted byte equals the bank value sampled in its own FETCH cycle, not the later value.

Source files
------------

// File: rtl/oa_tx.sv
// oa_tx: reads NUM_BYTES bytes from the register bank and sends each byte as 8N1 UART on tx.
// Latency: tx falls 2 cycles after start; each byte costs 1 + 10*CLKS_PER_BIT cycles; done is a 1-cycle pulse.
// Backpressure: none; start is honoured only in IDLE and ignored while busy. OA_TX_CHECKSUM_EN appends an XOR checksum byte.
module oa_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int NUM_BYTES    = 55
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [5:0] rd_idx,
  input  logic [7:0] rd_data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_DATA,
    S_STOP,
`ifdef OA_TX_CHECKSUM_EN
    S_CSUM_LOAD,
`endif
    S_DONE
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [5:0]  IDX_LAST  = 6'(NUM_BYTES - 1);

  state_t      state;
  logic [15:0] baud;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
`ifdef OA_TX_CHECKSUM_EN
  logic [7:0]  csum;
  logic        last_byte;
`endif

  // Frame sequencer: baud timing, bit shifting and registered line/status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_idx  <= 6'd0;
      baud    <= 16'd0;
      bit_cnt <= 3'd0;
      shift   <= 8'd0;
`ifdef OA_TX_CHECKSUM_EN
      csum      <= 8'd0;
      last_byte <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          tx      <= 1'b1;
          baud    <= 16'd0;
          bit_cnt <= 3'd0;
`ifdef OA_TX_CHECKSUM_EN
          csum      <= 8'd0;
          last_byte <= 1'b0;
`endif
          if (start) begin
            busy   <= 1'b1;
            rd_idx <= 6'd0;
            state  <= S_FETCH;
          end
        end
        S_FETCH: begin
          // rd_data is combinational on rd_idx, so it is valid in this cycle.
          shift <= rd_data;
`ifdef OA_TX_CHECKSUM_EN
          csum  <= csum ^ rd_data;
`endif
          tx    <= 1'b0;
          state <= S_START;
        end
        S_START: begin
          if (baud == BAUD_LAST) begin
            baud    <= 16'd0;
            bit_cnt <= 3'd0;
            tx      <= shift[0];
            state   <= S_DATA;
          end else begin
            baud <= baud + 16'd1;
          end
        end
        S_DATA: begin
          if (baud == BAUD_LAST) begin
            baud <= 16'd0;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end
        S_STOP: begin
          if (baud == BAUD_LAST) begin
            baud <= 16'd0;
`ifdef OA_TX_CHECKSUM_EN
            if (last_byte) begin
              done   <= 1'b1;
              busy   <= 1'b0;
              rd_idx <= 6'd0;
              state  <= S_DONE;
            end else if (rd_idx < IDX_LAST) begin
              rd_idx <= rd_idx + 6'd1;
              state  <= S_FETCH;
            end else begin
              state <= S_CSUM_LOAD;
            end
`else
            if (rd_idx < IDX_LAST) begin
              rd_idx <= rd_idx + 6'd1;
              state  <= S_FETCH;
            end else begin
              done   <= 1'b1;
              busy   <= 1'b0;
              rd_idx <= 6'd0;
              state  <= S_DONE;
            end
`endif
          end else begin
            baud <= baud + 16'd1;
          end
        end
`ifdef OA_TX_CHECKSUM_EN
        S_CSUM_LOAD: begin
          // rd_idx stays on the last data index; the flag ends the frame after this byte.
          shift     <= csum;
          last_byte <= 1'b1;
          tx        <= 1'b0;
          state     <= S_START;
        end
`endif
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oa_tx.sv
// tb_oa_tx: randomized frames on oa_tx decoded by a UART line model and compared to bank contents.
// Latency: frame timing is checked against 1 + B*(10*CLKS_PER_BIT+1) cycles after start.
// Backpressure: none; start pulses during busy and in the done cycle must be ignored.
module tb_oa_tx;

  localparam int C  = 4;
  localparam int NB = 3;
  localparam int C1 = 2;
`ifdef OA_TX_CHECKSUM_EN
  localparam int NF  = NB + 1;
  localparam int NF1 = 2;
`else
  localparam int NF  = NB;
  localparam int NF1 = 1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       start1;
  logic [5:0] rd_idx;
  logic [5:0] rd_idx1;
  logic [7:0] rd_data;
  logic [7:0] rd_data1;
  logic       tx, busy, done;
  logic       tx1, busy1, done1;

  logic [7:0] bank [64];
  logic [7:0] exp_b [64];
  logic [7:0] rx_q [$];
  int         idx_seq [$];
  int         frm_err = 0;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign rd_data  = bank[rd_idx];
  assign rd_data1 = 8'h00;

  oa_tx #(.CLKS_PER_BIT(C), .NUM_BYTES(NB)) dut (
    .clk(clk), .reset(reset), .start(start), .rd_idx(rd_idx), .rd_data(rd_data),
    .tx(tx), .busy(busy), .done(done)
  );

  oa_tx #(.CLKS_PER_BIT(C1), .NUM_BYTES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .rd_idx(rd_idx1), .rd_data(rd_data1),
    .tx(tx1), .busy(busy1), .done(done1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // UART line model: find start bit, sample each bit at its middle.
  initial begin : uart_rx
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && tx === 1'b0) begin
        repeat (C / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (C) @(negedge clk);
          b[i] = tx;
        end
        repeat (C) @(negedge clk);
        if (tx !== 1'b1) frm_err++;
        rx_q.push_back(b);
      end
    end
  end

  // mode: 0 plain, 1 start spam while busy, 2 bank rewrite during STOP, 3 start in done cycle
  task automatic run_frame(input string tag, input int mode);
    int         t0;
    int         rel;
    bit         got_done;
    logic [5:0] last_idx;
    logic [7:0] x;
    for (int i = 0; i < NB; i++) exp_b[i] = bank[i];
    idx_seq.delete();
    rx_q.delete();
    frm_err  = 0;
    got_done = 1'b0;
    last_idx = 6'h3f;
    rel      = 0;
    @(negedge clk);
    start = 1'b1;
    t0    = cyc;
    for (int k = 0; k < NF * (10 * C + 1) + 20 && !got_done; k++) begin
      @(negedge clk);
      rel   = cyc - t0;
      start = (mode == 1) ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (rel == 1) check({tag, "_busy_t1"}, 32'(busy), 32'd1);
      if (rel == 2) check({tag, "_tx_fall_t2"}, 32'(tx), 32'd0);
      if (busy && rd_idx != last_idx) begin
        idx_seq.push_back(int'(rd_idx));
        last_idx = rd_idx;
      end
      if (mode == 2) begin
        for (int b = 0; b < NB - 1; b++) begin
          if (rel == 1 + b * (10 * C + 1) + 1 + 9 * C + 1) begin
            bank[b]     = 8'($urandom);
            bank[b + 1] = 8'($urandom);
            exp_b[b + 1] = bank[b + 1];
          end
        end
      end
      if (done) begin
        got_done = 1'b1;
        start    = (mode == 3);
      end
    end
    check({tag, "_done_seen"}, 32'(got_done), 32'd1);
    check({tag, "_done_cyc"}, rel, 1 + NF * (10 * C + 1));
    if (mode == 3) begin
      @(negedge clk);
      start = 1'b0;
      check({tag, "_start_at_done_ignored"}, 32'(busy), 32'd0);
      repeat (5) @(negedge clk);
      check({tag, "_still_idle"}, {31'd0, busy | ~tx}, 32'd0);
    end
    x = 8'h00;
    for (int i = 0; i < NB; i++) x = x ^ exp_b[i];
    if (NF > NB) exp_b[NB] = x;
    check({tag, "_nbytes"}, rx_q.size(), NF);
    for (int i = 0; i < NF && i < rx_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_b[i]));
    check({tag, "_stop_bits"}, frm_err, 0);
    check({tag, "_idx_len"}, idx_seq.size(), NB);
    for (int i = 0; i < NB && i < idx_seq.size(); i++)
      check($sformatf("%s_idx%0d", tag, i), idx_seq[i], i);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++) bank[i] = 8'($urandom);
  endtask

  initial begin : main
    int t0;
    int rel;
    int lows;
    int first_low;
    int run_len;
    bit in_run;
    bit run_end;
    bit d1_seen;

    reset  = 1'b0;
    start  = 1'b0;
    start1 = 1'b0;
    fill_random();
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_idx", 32'(rd_idx), 32'd0);
    check("rst_tx1", 32'(tx1), 32'd1);

    reset = 1'b1;
    lows  = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    check("idle_1000", lows, 0);

    bank[0] = 8'hA5;
    bank[1] = 8'h3C;
    bank[2] = 8'hFF;
    run_frame("fixed", 0);

    fill_random();
    run_frame("spam", 1);
    run_frame("repeat", 0);
    fill_random();
    run_frame("start_on_done", 3);
    fill_random();
    run_frame("bank_chg", 2);

    // Reset dropped during data bit 3 of byte 1.
    fill_random();
    @(negedge clk);
    start = 1'b1;
    t0    = cyc;
    @(negedge clk);
    start = 1'b0;
    rel   = cyc - t0;
    for (int k = 0; k < 200 && rel < 1 + (10 * C + 1) + 1 + C + 3 * C + 1; k++) begin
      @(negedge clk);
      rel = cyc - t0;
    end
    check("pre_rst_bit3", 32'(tx), 32'(bank[1][3]));
    check("pre_rst_busy", 32'(busy), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_idx", 32'(rd_idx), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (100) @(negedge clk);
    check("post_rst_idle", {31'd0, busy | ~tx}, 32'd0);
    fill_random();
    run_frame("post_rst", 0);

    for (int f = 0; f < 4; f++) begin
      fill_random();
      run_frame($sformatf("rand%0d", f), f % 2);
    end

    // Single all-zero byte at CLKS_PER_BIT=2.
    @(negedge clk);
    start1 = 1'b1;
    t0     = cyc;
    first_low = -1;
    run_len   = 0;
    in_run    = 1'b0;
    run_end   = 1'b0;
    d1_seen   = 1'b0;
    rel       = 0;
    for (int k = 0; k < 200 && !d1_seen; k++) begin
      @(negedge clk);
      start1 = 1'b0;
      rel    = cyc - t0;
      if (!run_end) begin
        if (tx1 === 1'b0) begin
          if (!in_run) first_low = rel;
          in_run = 1'b1;
          run_len++;
        end else if (in_run) begin
          run_end = 1'b1;
        end
      end
      if (done1) d1_seen = 1'b1;
    end
    check("one_first_low", first_low, 2);
    check("one_low_len", run_len, 18);
    check("one_done_cyc", d1_seen ? rel : -1, 1 + NF1 * (10 * C1 + 1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
